// File: rtl/store_buffer.sv
// Circular store buffer between the cache stage and the data cache, with load forwarding.
// Latency: a push is offered on wenable the cycle after its edge; forwarding is combinational.
// Backpressure: full drops pushes (even if popping the same cycle); pops only when store_success.
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'b00
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'b10
`endif

module store_buffer #(
    parameter int SB_ENTRIES       = 4,
    parameter int WORD_SIZE        = 32,
    parameter int SIZE_WRITE_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WORD_SIZE-1:0]          push_addr,
    input  logic [WORD_SIZE-1:0]          push_value,
    input  logic [SIZE_WRITE_WIDTH-1:0]   push_size,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(SB_ENTRIES):0]   count,
    output logic                          wenable,
    output logic [WORD_SIZE-1:0]          sb_addr,
    output logic [WORD_SIZE-1:0]          sb_value,
    output logic [SIZE_WRITE_WIDTH-1:0]   sb_size,
    input  logic                          store_success,
    input  logic                          ld_valid,
    input  logic [WORD_SIZE-1:0]          ld_addr,
    input  logic [SIZE_WRITE_WIDTH-1:0]   ld_size,
    output logic                          fwd_hit,
    output logic [WORD_SIZE-1:0]          fwd_data,
    output logic                          fwd_stall
);

    localparam int PW = $clog2(SB_ENTRIES);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SB_ENTRIES);
    localparam logic [SIZE_WRITE_WIDTH-1:0] SZ_BYTE = SIZE_WRITE_WIDTH'(`BYTE_SIZE);

    logic [PW-1:0]               head_q, head_d;
    logic [PW-1:0]               tail_q, tail_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        valid_q [SB_ENTRIES];
    logic                        valid_d [SB_ENTRIES];
    logic [WORD_SIZE-1:0]        addr_q  [SB_ENTRIES];
    logic [WORD_SIZE-1:0]        addr_d  [SB_ENTRIES];
    logic [WORD_SIZE-1:0]        value_q [SB_ENTRIES];
    logic [WORD_SIZE-1:0]        value_d [SB_ENTRIES];
    logic [SIZE_WRITE_WIDTH-1:0] size_q  [SB_ENTRIES];
    logic [SIZE_WRITE_WIDTH-1:0] size_d  [SB_ENTRIES];

    logic push_acc;
    logic pop;

    assign full     = (count_q == CNT_MAX);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign wenable  = !empty;
    assign push_acc = push && !full;
    assign pop      = store_success && !empty;

    always_comb begin
        sb_addr  = '0;
        sb_value = '0;
        sb_size  = '0;
        if (wenable) begin
            sb_addr  = addr_q[head_q];
            sb_value = value_q[head_q];
            sb_size  = size_q[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        value_d = value_q;
        size_d  = size_q;
        if (push_acc) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = push_addr;
            value_d[tail_q] = push_value;
            size_d[tail_q]  = push_size;
            tail_d          = tail_q + PTR_ONE;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_ONE;
        end
        if (push_acc && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push_acc) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < SB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                value_q[i] <= '0;
                size_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            value_q <= value_d;
            size_q  <= size_d;
        end
    end

    // Walk oldest to youngest so the youngest match overrides; a byte store at a
    // different offset leaves the older result standing.
    logic [PW-1:0]        idx;
    logic [7:0]           sel_byte;
    logic                 ld_is_byte;

    always_comb begin
        fwd_hit    = 1'b0;
        fwd_stall  = 1'b0;
        fwd_data   = '0;
        idx        = '0;
        sel_byte   = '0;
        ld_is_byte = (ld_size == SZ_BYTE);
        if (ld_valid) begin
            for (int k = 0; k < SB_ENTRIES; k++) begin
                idx = head_q + PW'(k);
                if (valid_q[idx] && (addr_q[idx][WORD_SIZE-1:2] == ld_addr[WORD_SIZE-1:2])) begin
                    if (size_q[idx] != SZ_BYTE) begin
                        fwd_hit   = 1'b1;
                        fwd_stall = 1'b0;
                        if (ld_is_byte) begin
                            sel_byte = value_q[idx][{ld_addr[1:0], 3'b000} +: 8];
                            fwd_data = {{(WORD_SIZE-8){sel_byte[7]}}, sel_byte};
                        end else begin
                            fwd_data = value_q[idx];
                        end
                    end else if (ld_is_byte) begin
                        if (addr_q[idx][1:0] == ld_addr[1:0]) begin
                            fwd_hit   = 1'b1;
                            fwd_stall = 1'b0;
                            sel_byte  = value_q[idx][7:0];
                            fwd_data  = {{(WORD_SIZE-8){sel_byte[7]}}, sel_byte};
                        end
                    end else begin
                        fwd_hit   = 1'b0;
                        fwd_stall = 1'b1;
                        fwd_data  = '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: fill/wrap, push+pop interplay, forwarding, async reset.
module tb_store_buffer;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic [31:0] push_addr = '0;
    logic [31:0] push_value = '0;
    logic [1:0]  push_size = '0;
    logic        full, empty, wenable;
    logic [2:0]  count;
    logic [31:0] sb_addr, sb_value;
    logic [1:0]  sb_size;
    logic        store_success = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [1:0]  ld_size = '0;
    logic        fwd_hit, fwd_stall;
    logic [31:0] fwd_data;

    int n_checks = 0;
    int n_fail   = 0;

    store_buffer dut (
        .clk(clk), .rst(rst),
        .push(push), .push_addr(push_addr), .push_value(push_value), .push_size(push_size),
        .full(full), .empty(empty), .count(count),
        .wenable(wenable), .sb_addr(sb_addr), .sb_value(sb_value), .sb_size(sb_size),
        .store_success(store_success),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
        push = 1'b1; push_addr = a; push_value = v; push_size = s;
        tick();
        push = 1'b0;
    endtask

    task automatic do_pop();
        store_success = 1'b1;
        tick();
        store_success = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] s);
        ld_valid = 1'b1; ld_addr = a; ld_size = s;
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wenable", 32'(wenable), 32'd0);
        chk("rst_sb_addr", sb_addr, 32'd0);
        load(32'h0, SZ_W);
        chk("rst_fwd", {fwd_hit, fwd_stall, 30'd0} | fwd_data, 32'd0);
        ld_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Fill, first-push latency, overflow drop
        do_push(32'h10, 32'h1, SZ_W);
        chk("lat_wenable", 32'(wenable), 32'd1);
        chk("lat_sb_addr", sb_addr, 32'h10);
        chk("lat_sb_value", sb_value, 32'h1);
        do_push(32'h20, 32'h2, SZ_W);
        do_push(32'h30, 32'h3, SZ_W);
        do_push(32'h40, 32'h4, SZ_W);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        do_push(32'h50, 32'h5, SZ_W);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_sb_addr", sb_addr, 32'h10);

        // Pop 2, push 2 (tail wraps), drain in order
        chk("wrap_head0", sb_addr, 32'h10); do_pop();
        chk("wrap_head1", sb_addr, 32'h20); do_pop();
        chk("wrap_cnt2", 32'(count), 32'd2);
        do_push(32'h50, 32'h5, SZ_W);
        do_push(32'h60, 32'h6, SZ_W);
        chk("wrap_full", 32'(full), 32'd1);
        chk("wrap_head2", sb_addr, 32'h30); do_pop();
        chk("wrap_head3", sb_addr, 32'h40); do_pop();
        chk("wrap_head4", sb_addr, 32'h50); do_pop();
        chk("wrap_head5", sb_addr, 32'h60); do_pop();
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("wrap_sb_zero", sb_addr, 32'd0);
        do_pop();
        chk("pop_empty_ignored", 32'(count), 32'd0);

        // Simultaneous push+pop at count 2 and at full
        do_push(32'hA0, 32'hA, SZ_W);
        do_push(32'hB0, 32'hB, SZ_W);
        push = 1'b1; push_addr = 32'hC0; push_value = 32'hC; push_size = SZ_W;
        store_success = 1'b1;
        tick();
        push = 1'b0; store_success = 1'b0;
        chk("pp2_count", 32'(count), 32'd2);
        chk("pp2_head", sb_addr, 32'hB0);
        do_push(32'hD0, 32'hD, SZ_W);
        do_push(32'hE0, 32'hE, SZ_W);
        chk("pp_full", 32'(full), 32'd1);
        push = 1'b1; push_addr = 32'hF0; push_value = 32'hF; push_size = SZ_W;
        store_success = 1'b1;
        tick();
        push = 1'b0; store_success = 1'b0;
        chk("ppf_count", 32'(count), 32'd3);
        chk("ppf_head", sb_addr, 32'hC0); do_pop();
        chk("ppf_head1", sb_addr, 32'hD0); do_pop();
        chk("ppf_head2", sb_addr, 32'hE0); do_pop();
        chk("ppf_drained", 32'(empty), 32'd1);

        // Forwarding
        do_push(32'h100, 32'h11223344, SZ_W);
        do_push(32'h101, 32'h00000080, SZ_B);
        chk("fwd_size_head", 32'(sb_size), 32'(SZ_W));
        load(32'h100, SZ_W);
        chk("fwd_w_stall", 32'(fwd_stall), 32'd1);
        chk("fwd_w_hit", 32'(fwd_hit), 32'd0);
        load(32'h101, SZ_B);
        chk("fwd_b1_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_b1_data", fwd_data, 32'hFFFFFF80);
        chk("fwd_b1_stall", 32'(fwd_stall), 32'd0);
        load(32'h102, SZ_B);
        chk("fwd_b2_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_b2_data", fwd_data, 32'h00000022);
        load(32'h104, SZ_W);
        chk("fwd_miss", 32'(fwd_hit | fwd_stall), 32'd0);
        ld_valid = 1'b0; #1;
        chk("fwd_idle", {fwd_hit, fwd_stall, 30'd0} | fwd_data, 32'd0);
        // Entry pushed this cycle does not forward
        push = 1'b1; push_addr = 32'h300; push_value = 32'h5A5A5A5A; push_size = SZ_W;
        load(32'h300, SZ_W);
        chk("fwd_push_same_cycle", 32'(fwd_hit), 32'd0);
        tick();
        push = 1'b0;
        load(32'h300, SZ_W);
        chk("fwd_push_next", fwd_data, 32'h5A5A5A5A);
        // Entry popped this cycle still forwards
        store_success = 1'b1;
        load(32'h103, SZ_B);
        chk("fwd_pop_same_cycle", fwd_data, 32'h00000011);
        tick();
        store_success = 1'b0;
        load(32'h103, SZ_B);
        chk("fwd_after_pop", 32'(fwd_hit), 32'd0);
        ld_valid = 1'b0;
        do_pop(); do_pop();
        chk("fwd_drained", 32'(empty), 32'd1);

        // Youngest match wins
        do_push(32'h200, 32'hAAAA0000, SZ_W);
        do_push(32'h200, 32'h0000BBBB, SZ_W);
        load(32'h200, SZ_W);
        chk("young_hit", 32'(fwd_hit), 32'd1);
        chk("young_data", fwd_data, 32'h0000BBBB);
        ld_valid = 1'b0;

        // Async reset mid-operation
        do_push(32'h210, 32'h3, SZ_W);
        chk("ar_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_empty", 32'(empty), 32'd1);
        chk("ar_wenable", 32'(wenable), 32'd0);
        chk("ar_count0", 32'(count), 32'd0);
        chk("ar_sb_addr", sb_addr, 32'd0);
        tick();
        rst = 1'b0;
        do_push(32'h400, 32'h44, SZ_B);
        chk("ar_first_push", 32'(count), 32'd1);
        chk("ar_first_addr", sb_addr, 32'h400);
        chk("ar_first_size", 32'(sb_size), 32'(SZ_B));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
